// File: rtl/jtag_engine_pkg.sv
// Shared types and constants for the JTAG shift engine: command encoding,
// controller states, TMS walk sequences (LSB emitted first) and common IR opcodes.
package jtag_engine_pkg;

    typedef enum logic [1:0] {
        TAP_RESET  = 2'd0,
        SHIFT_IR   = 2'd1,
        SHIFT_DR   = 2'd2,
        TRST_PULSE = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRST,
        ST_TMS_SEQ,
        ST_SHIFT,
        ST_POST,
        ST_DONE
    } state_e;

    // TMS walks from Run-Test/Idle (or anywhere, for reset); *_LAST is the last bit index.
    localparam logic [5:0] TMS_RESET_SEQ  = 6'b011111;
    localparam int         TMS_RESET_LAST = 5;
    localparam logic [5:0] TMS_IR_SEQ     = 6'b000011;
    localparam int         TMS_IR_LAST    = 3;
    localparam logic [5:0] TMS_DR_SEQ     = 6'b000001;
    localparam int         TMS_DR_LAST    = 2;
    localparam logic [1:0] TMS_POST_SEQ   = 2'b01;

    localparam logic [4:0] IR_IDCODE     = 5'h01;
    localparam logic [4:0] IR_PULP_TAP   = 5'h04;
    localparam logic [4:0] IR_SOC_CONFIG = 5'h06;
    localparam logic [4:0] IR_BYPASS     = 5'h1F;

endpackage

// File: rtl/jtag_tck_div.sv
// TCK generator: half-period counter that runs only while enabled and flags
// the clk cycle in which TCK rises or falls.
module jtag_tck_div #(
    parameter int TCK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tck,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap     = en && (cnt == CNT_W'(TCK_DIV - 1));
    assign rise_stb = wrap && !tck;
    assign fall_stb = wrap && tck;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/jtag_shift_engine.sv
// JTAG master: turns TAP reset / IR shift / DR shift / TRST commands into
// cycle-accurate TCK/TMS/TDI waveforms and returns the TDO bits captured.
module jtag_shift_engine
    import jtag_engine_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int IR_LEN  = 5,
    parameter int TCK_DIV = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [1:0]                   cmd_type_i,
    input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len_i,
    input  logic [MAX_LEN-1:0]           cmd_data_i,
    output logic                         rsp_valid_o,
    output logic [MAX_LEN-1:0]           rsp_data_o,
    output logic                         jtag_tck_o,
    output logic                         jtag_tms_o,
    output logic                         jtag_tdi_o,
    output logic                         jtag_trst_no,
    input  logic                         jtag_tdo_i
);

    localparam int LEN_W       = $clog2(MAX_LEN + 1);
    localparam int IDX_W       = $clog2(MAX_LEN);
    localparam int TRST_CYCLES = 8 * TCK_DIV;
    localparam int TCNT_W      = $clog2(TRST_CYCLES);

    state_e             state_q, state_d;
    cmd_type_e          type_q, type_d, cmd_type;
    logic [LEN_W-1:0]   bit_q, bit_d, len_q, len_d, seq_last_q, seq_last_d, eff_len;
    logic [5:0]         seq_q, seq_d;
    logic [MAX_LEN-1:0] data_q, data_d, cap_q, cap_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic               tms_q, tms_d, tdi_q, tdi_d, trst_q, trst_d;
    logic               armed_q, accept, tck_en, tck, rise_stb, fall_stb;

    assign cmd_type    = cmd_type_e'(cmd_type_i);
    assign cmd_ready_o = (state_q == ST_IDLE) && armed_q;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign tck_en      = (state_q == ST_TMS_SEQ) || (state_q == ST_SHIFT) || (state_q == ST_POST);

    jtag_tck_div #(.TCK_DIV(TCK_DIV)) u_tck_div (
        .clk      (clk_i),
        .rst      (rst_i),
        .en       (tck_en),
        .tck      (tck),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_comb begin
        if (cmd_len_i == '0) begin
            eff_len = (cmd_type == SHIFT_IR) ? LEN_W'(IR_LEN) : LEN_W'(1);
        end else if (cmd_len_i > LEN_W'(MAX_LEN)) begin
            eff_len = LEN_W'(MAX_LEN);
        end else begin
            eff_len = cmd_len_i;
        end
    end

    // TMS/TDI advance only on falling TCK; TDO is captured only on SHIFT rises.
    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        bit_d      = bit_q;
        len_d      = len_q;
        seq_d      = seq_q;
        seq_last_d = seq_last_q;
        data_d     = data_q;
        cap_d      = cap_q;
        tcnt_d     = tcnt_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        trst_d     = trst_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    type_d  = cmd_type;
                    len_d   = eff_len;
                    data_d  = cmd_data_i;
                    cap_d   = '0;
                    bit_d   = '0;
                    tcnt_d  = '0;
                    tdi_d   = 1'b0;
                    state_d = ST_TMS_SEQ;
                    case (cmd_type)
                        TAP_RESET: begin
                            seq_d      = TMS_RESET_SEQ;
                            seq_last_d = LEN_W'(TMS_RESET_LAST);
                        end
                        SHIFT_IR: begin
                            seq_d      = TMS_IR_SEQ;
                            seq_last_d = LEN_W'(TMS_IR_LAST);
                        end
                        SHIFT_DR: begin
                            seq_d      = TMS_DR_SEQ;
                            seq_last_d = LEN_W'(TMS_DR_LAST);
                        end
                        TRST_PULSE: begin
                            trst_d  = 1'b0;
                            state_d = ST_TRST;
                        end
                    endcase
                    tms_d = (cmd_type == TRST_PULSE) ? 1'b1 : seq_d[0];
                end
            end
            ST_TRST: begin
                if (tcnt_q == TCNT_W'(TRST_CYCLES - 1)) begin
                    trst_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            ST_TMS_SEQ: begin
                if (fall_stb) begin
                    if (bit_q != seq_last_q) begin
                        bit_d = bit_q + LEN_W'(1);
                        tms_d = seq_q[bit_d[2:0]];
                    end else if (type_q == TAP_RESET) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                        bit_d   = '0;
                        tdi_d   = data_q[0];
                        tms_d   = (len_q == LEN_W'(1));
                    end
                end
            end
            ST_SHIFT: begin
                if (rise_stb) begin
                    cap_d[bit_q[IDX_W-1:0]] = jtag_tdo_i;
                end
                if (fall_stb) begin
                    if (bit_q == len_q - LEN_W'(1)) begin
                        state_d = ST_POST;
                        bit_d   = '0;
                        tdi_d   = 1'b0;
                        tms_d   = TMS_POST_SEQ[0];
                    end else begin
                        bit_d = bit_q + LEN_W'(1);
                        tdi_d = data_q[bit_d[IDX_W-1:0]];
                        tms_d = (bit_d == len_q - LEN_W'(1));
                    end
                end
            end
            ST_POST: begin
                if (fall_stb) begin
                    if (bit_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_d = LEN_W'(1);
                        tms_d = TMS_POST_SEQ[1];
                    end
                end
            end
            ST_DONE: begin
                tms_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // TMS resets high so an untouched TAP drifts toward Test-Logic-Reset, never into a shift.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            type_q     <= TAP_RESET;
            bit_q      <= '0;
            len_q      <= '0;
            seq_q      <= '0;
            seq_last_q <= '0;
            data_q     <= '0;
            cap_q      <= '0;
            tcnt_q     <= '0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            trst_q     <= 1'b1;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            bit_q      <= bit_d;
            len_q      <= len_d;
            seq_q      <= seq_d;
            seq_last_q <= seq_last_d;
            data_q     <= data_d;
            cap_q      <= cap_d;
            tcnt_q     <= tcnt_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            trst_q     <= trst_d;
            armed_q    <= 1'b1;
        end
    end

    assign rsp_valid_o  = (state_q == ST_DONE);
    assign rsp_data_o   = cap_q;
    assign jtag_tck_o   = tck;
    assign jtag_tms_o   = tms_q;
    assign jtag_tdi_o   = tdi_q;
    assign jtag_trst_no = trst_q;

endmodule
